// File: rtl/nf10_axis_pkt_gen.sv
// nf10_axis_pkt_gen: replays a beat template as bursts of AXI-Stream packets.
// Define PKT_GEN_THROTTLE_EN to gate beat presentation with a 16-bit LFSR.
module nf10_axis_pkt_gen #(
   parameter  int DATA_WIDTH  = 256,
   parameter  int TUSER_WIDTH = 128,
   parameter  int MAX_BEATS   = 16,
   parameter  int CNT_WIDTH   = 16,
   localparam int AW          = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
   localparam int BPB         = DATA_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tmpl_wr_en,
   input  logic [AW-1:0]          tmpl_wr_addr,
   input  logic [DATA_WIDTH-1:0]  tmpl_wr_data,
   input  logic                   start,
   input  logic [15:0]            pkt_len_bytes,
   input  logic [CNT_WIDTH-1:0]   pkt_count,
   input  logic [7:0]             ipg_cycles,
   input  logic [TUSER_WIDTH-1:0] tuser_in,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_WIDTH-1:0]   pkts_sent,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [BPB-1:0]         m_axis_tstrb,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t                 state_q;
   logic [DATA_WIDTH-1:0]  mem_q [MAX_BEATS];
   logic [CNT_WIDTH-1:0]   cnt_q, pkts_q;
   logic [7:0]             ipg_q, gap_q;
   logic [TUSER_WIDTH-1:0] tuser_lat_q;
   logic [AW-1:0]          last_idx_q, beat_q;
   logic [BPB-1:0]         last_strb_q;
   logic [DATA_WIDTH-1:0]  tdata_q;
   logic [BPB-1:0]         tstrb_q;
   logic [TUSER_WIDTH-1:0] tuser_q;
   logic                   tvalid_q, tlast_q, busy_q, done_q;

   logic [31:0]            len_w, beats_w, rem_w;
   logic                   clamp_w;
   logic [AW-1:0]          calc_last_idx;
   logic [BPB-1:0]         calc_strb;
   logic                   start_ok, cnt_last, gate_ok;
   logic                   ld_en, ld_last;
   logic [AW-1:0]          ld_idx, ld_last_idx;
   logic [BPB-1:0]         ld_last_strb;
   logic [TUSER_WIDTH-1:0] ld_tuser;

   // Over-long packets are truncated to a full template of full beats.
   always_comb begin
      len_w         = {16'd0, pkt_len_bytes};
      beats_w       = (len_w + 32'(BPB - 1)) / 32'(BPB);
      rem_w         = len_w % 32'(BPB);
      clamp_w       = beats_w > 32'(MAX_BEATS);
      calc_last_idx = clamp_w ? AW'(MAX_BEATS - 1) : AW'(beats_w - 32'd1);
      for (int i = 0; i < BPB; i++)
         calc_strb[i] = clamp_w || (rem_w == 32'd0) || (32'(i) < rem_w);
   end

   assign start_ok = start && (pkt_len_bytes != 16'd0) && (pkt_count != '0);
   assign cnt_last = (pkts_q + CNT_WIDTH'(1)) == cnt_q;

`ifdef PKT_GEN_THROTTLE_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (reset)
         lfsr_q <= 16'hACE1;
      else
         lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign gate_ok = lfsr_q[1:0] != 2'b00;
`else
   assign gate_ok = 1'b1;
`endif

   // Selects the beat to put on the bus at the coming edge, if any.
   always_comb begin
      ld_en  = 1'b0;
      ld_idx = '0;
      case (state_q)
         IDLE: ld_en = start_ok;
         SEND: begin
            if (!tvalid_q) begin
               ld_en  = 1'b1;
               ld_idx = beat_q;
            end else if (m_axis_tready) begin
               if (!tlast_q) begin
                  ld_en  = 1'b1;
                  ld_idx = beat_q + 1'b1;
               end else begin
                  ld_en = !cnt_last && (ipg_q == 8'd0);
               end
            end
         end
         GAP:     ld_en = gap_q == 8'd1;
         default: ld_en = 1'b0;
      endcase
   end

   assign ld_last_idx  = (state_q == IDLE) ? calc_last_idx : last_idx_q;
   assign ld_last_strb = (state_q == IDLE) ? calc_strb : last_strb_q;
   assign ld_tuser     = (state_q == IDLE) ? tuser_in : tuser_lat_q;
   assign ld_last      = ld_idx == ld_last_idx;

   always_ff @(posedge clk) begin
      if (state_q == IDLE && tmpl_wr_en)
         mem_q[tmpl_wr_addr] <= tmpl_wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pkts_q      <= '0;
         ipg_q       <= '0;
         gap_q       <= '0;
         tuser_lat_q <= '0;
         last_idx_q  <= '0;
         last_strb_q <= '0;
         beat_q      <= '0;
         tdata_q     <= '0;
         tstrb_q     <= '0;
         tuser_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  cnt_q       <= pkt_count;
                  ipg_q       <= ipg_cycles;
                  tuser_lat_q <= tuser_in;
                  last_idx_q  <= calc_last_idx;
                  last_strb_q <= calc_strb;
                  pkts_q      <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (tvalid_q && m_axis_tready && tlast_q) begin
                  pkts_q <= pkts_q + CNT_WIDTH'(1);
                  if (cnt_last) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (ipg_q != 8'd0) begin
                     state_q <= GAP;
                     gap_q   <= ipg_q;
                  end
               end
            end
            GAP: begin
               gap_q <= gap_q - 8'd1;
               if (gap_q == 8'd1)
                  state_q <= SEND;
            end
            default: state_q <= IDLE;
         endcase

         if (ld_en)
            beat_q <= ld_idx;
         if (ld_en && gate_ok) begin
            tvalid_q <= 1'b1;
            tdata_q  <= mem_q[ld_idx];
            tstrb_q  <= ld_last ? ld_last_strb : '1;
            tuser_q  <= (ld_idx == '0) ? ld_tuser : '0;
            tlast_q  <= ld_last;
         end else if (ld_en || (tvalid_q && m_axis_tready)) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
         end
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pkts_sent     = pkts_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tstrb  = tstrb_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

endmodule
